// File: rtl/rfile_transmitter_if.sv
// rfile_transmitter_if
// Bundles the register-file read port, the start/status handshake and the
// one-wire serial link of the register-file transmitter. The master side
// is the transmitter; the slave side is whatever owns the register file,
// issues start and listens to the link.
interface rfile_transmitter_if #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 4
);
   logic              start;
   logic [DATA_W-1:0] rfdata;
   logic [ADDR_W-1:0] rfaddr;
   logic              link;
   logic              busy;
   logic              done;

   // Transmitter view: reads the register file and drives the link/status.
   modport master (
      input  start,
      input  rfdata,
      output rfaddr,
      output link,
      output busy,
      output done
   );

   // Register file / controller / link-partner view.
   modport slave (
      output start,
      output rfdata,
      input  rfaddr,
      input  link,
      input  busy,
      input  done
   );
endinterface

// File: rtl/rfile_transmitter.sv
// rfile_transmitter
// Sweeps a small register file and sends every entry as a packet
// {1'b1, addr, data}, MSB first, on a single wire. Packets within a sweep
// are sent back to back, with no idle bit between them. A one-cycle done
// pulse follows the last bit of each sweep.
//
// Optional feature, selected at compile time with RFTX_AUTO_REPEAT_EN:
// when start is high at the edge that ends the last bit of a sweep, the
// next sweep begins at that same edge. The link stays continuous and busy
// stays high. Without the macro every sweep passes through DONE and IDLE.
module rfile_transmitter #(
   parameter int NREG   = 4,
   parameter int ADDR_W = 2,
   parameter int DATA_W = 4
) (
   input  logic                clock,
   input  logic                clear_n,
   rfile_transmitter_if.master bus
);

   // One packet is the start bit, the address field and the data field.
   localparam int PLEN   = 1 + ADDR_W + DATA_W;
   localparam int BCNT_W = $clog2(PLEN);

   localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(PLEN - 1);
   localparam logic [ADDR_W-1:0] LAST_PKT = ADDR_W'(NREG - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [ADDR_W-1:0] pkt_q,   pkt_d;
   logic [BCNT_W-1:0] bcnt_q,  bcnt_d;
   logic [PLEN-1:0]   shift_q, shift_d;
   logic              done_q,  done_d;

   logic [PLEN-1:0]   loadPkt;
   logic [ADDR_W-1:0] nextAddr;

   // The address counter wraps after the last register, so it is already
   // back at 0 when a sweep finishes. rfaddr therefore never points past
   // the last register, and the next sweep (or an auto-repeat) starts at 0.
   assign nextAddr = (addr_q == LAST_PKT) ? '0 : addr_q + ADDR_W'(1);

   // The packet is captured from the read data on the load edge. Later
   // changes to rfdata cannot disturb the packet in flight.
   assign loadPkt  = {1'b1, addr_q, bus.rfdata};

   // Next-state logic: idle/load, shift and chain packets, finish sweep.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      pkt_d   = pkt_q;
      bcnt_d  = bcnt_q;
      shift_d = shift_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            addr_d = '0;
            if (bus.start) begin
               shift_d = loadPkt;
               addr_d  = nextAddr;
               pkt_d   = '0;
               bcnt_d  = '0;
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            if (bcnt_q != LAST_BIT) begin
               shift_d = {shift_q[PLEN-2:0], 1'b0};
               bcnt_d  = bcnt_q + BCNT_W'(1);
            end else if (pkt_q != LAST_PKT) begin
               // Chain the next packet with no gap on the link.
               shift_d = loadPkt;
               addr_d  = nextAddr;
               pkt_d   = pkt_q + ADDR_W'(1);
               bcnt_d  = '0;
            end else begin
               done_d = 1'b1;
`ifdef RFTX_AUTO_REPEAT_EN
               if (bus.start) begin
                  // Restart the sweep at address 0 on this same edge.
                  shift_d = loadPkt;
                  addr_d  = nextAddr;
                  pkt_d   = '0;
                  bcnt_d  = '0;
               end else begin
                  shift_d = '0;
                  addr_d  = '0;
                  pkt_d   = '0;
                  bcnt_d  = '0;
                  state_d = ST_DONE;
               end
`else
               shift_d = '0;
               addr_d  = '0;
               pkt_d   = '0;
               bcnt_d  = '0;
               state_d = ST_DONE;
`endif
            end
         end

         ST_DONE: begin
            // start is deliberately ignored here; nothing is queued.
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            addr_d  = '0;
            pkt_d   = '0;
            bcnt_d  = '0;
            shift_d = '0;
         end
      endcase
   end

   // State registers. The synchronous clear aborts any sweep at once.
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         pkt_q   <= '0;
         bcnt_q  <= '0;
         shift_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         pkt_q   <= pkt_d;
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
         done_q  <= done_d;
      end
   end

   // The link carries data only while shifting; it idles low otherwise.
   assign bus.link   = (state_q == ST_SHIFT) & shift_q[PLEN-1];
   assign bus.busy   = (state_q == ST_SHIFT);
   assign bus.done   = done_q;
   assign bus.rfaddr = addr_q;

endmodule

// File: tb/tb_rfile_transmitter.sv
// tb_rfile_transmitter
// Drives two transmitters, one with four registers and one with three. The
// bench predicts the serial stream from the register contents captured
// before each sweep, and decodes the link with a behavioural receiver.
`timescale 1ns/1ps
module tb_rfile_transmitter;

   localparam int ADDR_W = 2;
   localparam int DATA_W = 4;
   localparam int PLEN   = 1 + ADDR_W + DATA_W;

   logic clock;
   logic clear_n;

   int errors = 0;
   int checks = 0;

   logic [DATA_W-1:0] rfA  [4];
   logic [DATA_W-1:0] rfB  [4];
   logic [DATA_W-1:0] snap [4];

   logic [ADDR_W-1:0] rxAddr [$];
   logic [DATA_W-1:0] rxData [$];
   logic [PLEN-1:0]   rxShift;
   int                rxCnt;

   rfile_transmitter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busA ();
   rfile_transmitter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busB ();

   rfile_transmitter #(.NREG(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dutA (
      .clock   (clock),
      .clear_n (clear_n),
      .bus     (busA)
   );

   rfile_transmitter #(.NREG(3), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dutB (
      .clock   (clock),
      .clear_n (clear_n),
      .bus     (busB)
   );

   assign busA.rfdata = rfA[busA.rfaddr];
   assign busB.rfdata = rfB[busB.rfaddr];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Expected link bit at cycle c of a sweep: packet c/PLEN carries its own
   // index as address and the captured register value as data, MSB first.
   function automatic logic exp_link(input int c);
      int p;
      int b;
      logic [PLEN-1:0] pk;
      p  = c / PLEN;
      b  = c % PLEN;
      pk = {1'b1, ADDR_W'(p), snap[p]};
      return pk[PLEN-1-b];
   endfunction

   // Behavioural receiver: a 1 on an idle link starts a packet; after
   // PLEN bits the address and data fields are recorded as a write.
   task automatic rx_step(input logic b);
      if (rxCnt == 0) begin
         if (b) begin
            rxShift = PLEN'(1);
            rxCnt   = 1;
         end
      end else begin
         rxShift = {rxShift[PLEN-2:0], b};
         rxCnt++;
         if (rxCnt == PLEN) begin
            rxAddr.push_back(rxShift[PLEN-2:DATA_W]);
            rxData.push_back(rxShift[DATA_W-1:0]);
            rxCnt = 0;
         end
      end
   endtask

   task automatic test_reset();
      clear_n    = 1'b0;
      busA.start = 1'b0;
      busB.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rfA[i] = '0;
         rfB[i] = '0;
      end
      repeat (3) @(negedge clock);
      checks++;
      if (busA.link !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_link actual=%b required=0", busA.link);
      end
      checks++;
      if (busA.busy !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_busy actual=%b required=0", busA.busy);
      end
      checks++;
      if (busA.done !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_done actual=%b required=0", busA.done);
      end
      checks++;
      if (busA.rfaddr !== 2'd0) begin
         errors++; $display("[TB] FAIL reset_rfaddr actual=%0h required=0", busA.rfaddr);
      end
      checks++;
      if (busB.busy !== 1'b0 || busB.link !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_b actual=%b%b required=00", busB.busy, busB.link);
      end
      clear_n = 1'b1;
      @(negedge clock);
   endtask

   // Full sweeps: first the reference contents, then random contents.
   // Registers are scrambled once their packet is loaded.
   task automatic test_sweeps(input int nsweeps);
      for (int s = 0; s < nsweeps; s++) begin
         if (s == 0) begin
            rfA[0] = 4'hA; rfA[1] = 4'h5; rfA[2] = 4'h3; rfA[3] = 4'hC;
         end else begin
            for (int i = 0; i < 4; i++) rfA[i] = 4'($urandom_range(0, 15));
         end
         for (int i = 0; i < 4; i++) snap[i] = rfA[i];
         rxAddr.delete(); rxData.delete(); rxCnt = 0;
         repeat ($urandom_range(0, 3)) @(negedge clock);
         busA.start = 1'b1;
         @(negedge clock);
         busA.start = 1'b0;
         for (int c = 0; c < 4 * PLEN; c++) begin
            checks++;
            if (busA.link !== exp_link(c)) begin
               errors++; $display("[TB] FAIL sweep_link s=%0d c=%0d actual=%b required=%b", s, c, busA.link, exp_link(c));
            end
            checks++;
            if (busA.busy !== 1'b1 || busA.done !== 1'b0) begin
               errors++; $display("[TB] FAIL sweep_status s=%0d c=%0d busy/done actual=%b%b required=10", s, c, busA.busy, busA.done);
            end
            if (c < 3 * PLEN) begin
               checks++;
               if (busA.rfaddr !== ADDR_W'(c / PLEN + 1)) begin
                  errors++; $display("[TB] FAIL sweep_rfaddr s=%0d c=%0d actual=%0d required=%0d", s, c, busA.rfaddr, c / PLEN + 1);
               end
            end
            rx_step(busA.link);
            rfA[c / PLEN] = 4'($urandom_range(0, 15));
            @(negedge clock);
         end
         checks++;
         if (busA.done !== 1'b1 || busA.busy !== 1'b0 || busA.link !== 1'b0) begin
            errors++; $display("[TB] FAIL sweep_end s=%0d done/busy/link actual=%b%b%b required=100", s, busA.done, busA.busy, busA.link);
         end
         rx_step(busA.link);
         @(negedge clock);
         checks++;
         if (busA.done !== 1'b0) begin
            errors++; $display("[TB] FAIL sweep_done_width s=%0d actual=%b required=0", s, busA.done);
         end
         checks++;
         if (rxAddr.size() != 4) begin
            errors++; $display("[TB] FAIL rx_count s=%0d actual=%0d required=4", s, rxAddr.size());
         end else begin
            for (int i = 0; i < 4; i++) begin
               checks++;
               if (rxAddr[i] !== ADDR_W'(i) || rxData[i] !== snap[i]) begin
                  errors++; $display("[TB] FAIL rx_write s=%0d i=%0d actual=%0h:%0h required=%0h:%0h", s, i, rxAddr[i], rxData[i], i, snap[i]);
               end
            end
         end
      end
   endtask

   // start pulsed mid-sweep and during DONE: neither may start anything.
   task automatic test_start_ignored();
      for (int i = 0; i < 4; i++) begin
         rfA[i]  = 4'($urandom_range(0, 15));
         snap[i] = rfA[i];
      end
      busA.start = 1'b1;
      @(negedge clock);
      busA.start = 1'b0;
      for (int c = 0; c < 4 * PLEN; c++) begin
         checks++;
         if (busA.link !== exp_link(c) || busA.busy !== 1'b1) begin
            errors++; $display("[TB] FAIL ignore_link c=%0d link/busy actual=%b%b required=%b1", c, busA.link, busA.busy, exp_link(c));
         end
         busA.start = (c == 9);
         @(negedge clock);
      end
      checks++;
      if (busA.done !== 1'b1) begin
         errors++; $display("[TB] FAIL ignore_done actual=%b required=1", busA.done);
      end
      busA.start = 1'b1;
      @(negedge clock);
      busA.start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (busA.link !== 1'b0 || busA.busy !== 1'b0 || busA.done !== 1'b0) begin
            errors++; $display("[TB] FAIL ignore_idle c=%0d link/busy/done actual=%b%b%b required=000", c, busA.link, busA.busy, busA.done);
         end
         @(negedge clock);
      end
   endtask

   // Synchronous clear in the middle of the third packet.
   task automatic test_reset_mid();
      int n;
      for (int i = 0; i < 4; i++) begin
         rfA[i]  = 4'($urandom_range(0, 15));
         snap[i] = rfA[i];
      end
      busA.start = 1'b1;
      @(negedge clock);
      busA.start = 1'b0;
      for (int c = 0; c < 16; c++) begin
         checks++;
         if (busA.link !== exp_link(c)) begin
            errors++; $display("[TB] FAIL abort_pre c=%0d actual=%b required=%b", c, busA.link, exp_link(c));
         end
         if (c == 15) clear_n = 1'b0;
         @(negedge clock);
      end
      clear_n = 1'b1;
      checks++;
      if (busA.link !== 1'b0 || busA.busy !== 1'b0 || busA.done !== 1'b0 || busA.rfaddr !== 2'd0) begin
         errors++; $display("[TB] FAIL abort_state link/busy/done/rfaddr actual=%b%b%b%0d required=0000", busA.link, busA.busy, busA.done, busA.rfaddr);
      end
      for (int c = 0; c < 12; c++) begin
         @(negedge clock);
         checks++;
         if (busA.done !== 1'b0 || busA.link !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_quiet c=%0d done/link actual=%b%b required=00", c, busA.done, busA.link);
         end
      end
      busA.start = 1'b1;
      @(negedge clock);
      busA.start = 1'b0;
      for (int c = 0; c < PLEN; c++) begin
         checks++;
         if (busA.link !== exp_link(c) || busA.rfaddr !== 2'd1) begin
            errors++; $display("[TB] FAIL abort_restart c=%0d link/rfaddr actual=%b/%0d required=%b/1", c, busA.link, busA.rfaddr, exp_link(c));
         end
         @(negedge clock);
      end
      n = 0;
      while (busA.done !== 1'b1 && n < 40) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (busA.done !== 1'b1) begin
         errors++; $display("[TB] FAIL abort_restart_done actual=%b required=1 (timeout)", busA.done);
      end
      @(negedge clock);
   endtask

   // Three-register instance: 21 link cycles, rfaddr never reaches 3.
   task automatic test_nreg3();
      rfB[0] = 4'hF; rfB[1] = 4'h0; rfB[2] = 4'h9; rfB[3] = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) snap[i] = rfB[i];
      rxAddr.delete(); rxData.delete(); rxCnt = 0;
      busB.start = 1'b1;
      @(negedge clock);
      busB.start = 1'b0;
      for (int c = 0; c < 3 * PLEN; c++) begin
         checks++;
         if (busB.link !== exp_link(c) || busB.busy !== 1'b1) begin
            errors++; $display("[TB] FAIL n3_link c=%0d link/busy actual=%b%b required=%b1", c, busB.link, busB.busy, exp_link(c));
         end
         checks++;
         if (busB.rfaddr === 2'd3 || $isunknown(busB.rfaddr)) begin
            errors++; $display("[TB] FAIL n3_rfaddr c=%0d actual=%0d required=0..2", c, busB.rfaddr);
         end
         rx_step(busB.link);
         @(negedge clock);
      end
      checks++;
      if (busB.done !== 1'b1 || busB.busy !== 1'b0 || busB.link !== 1'b0) begin
         errors++; $display("[TB] FAIL n3_end done/busy/link actual=%b%b%b required=100", busB.done, busB.busy, busB.link);
      end
      checks++;
      if (rxAddr.size() != 3) begin
         errors++; $display("[TB] FAIL n3_rx_count actual=%0d required=3", rxAddr.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (rxAddr[i] !== ADDR_W'(i) || rxData[i] !== snap[i]) begin
               errors++; $display("[TB] FAIL n3_rx_write i=%0d actual=%0h:%0h required=%0h:%0h", i, rxAddr[i], rxData[i], i, snap[i]);
            end
         end
      end
      @(negedge clock);
   endtask

   // start held high across the end of a sweep.
   task automatic test_back_to_back();
      int n;
      for (int i = 0; i < 4; i++) begin
         rfA[i]  = 4'($urandom_range(0, 15));
         snap[i] = rfA[i];
      end
      busA.start = 1'b1;
      @(negedge clock);
`ifdef RFTX_AUTO_REPEAT_EN
      for (int c = 0; c < 8 * PLEN; c++) begin
         checks++;
         if (busA.link !== exp_link(c % (4 * PLEN)) || busA.busy !== 1'b1) begin
            errors++; $display("[TB] FAIL repeat_link c=%0d link/busy actual=%b%b required=%b1", c, busA.link, busA.busy, exp_link(c % (4 * PLEN)));
         end
         checks++;
         if (busA.done !== (c == 4 * PLEN)) begin
            errors++; $display("[TB] FAIL repeat_done c=%0d actual=%b required=%b", c, busA.done, (c == 4 * PLEN));
         end
         if (c == 4 * PLEN) busA.start = 1'b0;
         @(negedge clock);
      end
      checks++;
      if (busA.done !== 1'b1 || busA.busy !== 1'b0) begin
         errors++; $display("[TB] FAIL repeat_end done/busy actual=%b%b required=10", busA.done, busA.busy);
      end
      n = 0;
`else
      for (int c = 0; c < 4 * PLEN; c++) begin
         checks++;
         if (busA.link !== exp_link(c) || busA.busy !== 1'b1) begin
            errors++; $display("[TB] FAIL hold_link c=%0d link/busy actual=%b%b required=%b1", c, busA.link, busA.busy, exp_link(c));
         end
         @(negedge clock);
      end
      checks++;
      if (busA.link !== 1'b0 || busA.busy !== 1'b0 || busA.done !== 1'b1) begin
         errors++; $display("[TB] FAIL hold_done link/busy/done actual=%b%b%b required=001", busA.link, busA.busy, busA.done);
      end
      @(negedge clock);
      checks++;
      if (busA.link !== 1'b0 || busA.busy !== 1'b0 || busA.done !== 1'b0) begin
         errors++; $display("[TB] FAIL hold_gap link/busy/done actual=%b%b%b required=000", busA.link, busA.busy, busA.done);
      end
      @(negedge clock);
      checks++;
      if (busA.link !== 1'b1 || busA.busy !== 1'b1) begin
         errors++; $display("[TB] FAIL hold_restart link/busy actual=%b%b required=11", busA.link, busA.busy);
      end
      busA.start = 1'b0;
      n = 0;
      while (busA.done !== 1'b1 && n < 40) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (busA.done !== 1'b1) begin
         errors++; $display("[TB] FAIL hold_second_done actual=%b required=1 (timeout)", busA.done);
      end
`endif
      @(negedge clock);
   endtask

   initial begin
      test_reset();
      test_sweeps(6);
      test_start_ignored();
      test_reset_mid();
      test_nreg3();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] simulation did not finish");
   end

endmodule
